// File: rtl/fft_twiddle_addr_gen.sv
// Twiddle ROM address sequencer for a radix-2 DIT FFT.
// After a start request it steps through every stage and butterfly, drives the
// twiddle ROM address, and emits the matching butterfly indices one cycle later
// so that they line up with the ROM read data.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   start      one-cycle request to run a full schedule (ignored while busy)
//   adv        issue enable; low pauses the schedule
//   addr       twiddle ROM address (ADDR_BASE + k)
//   wr_ena     ROM write enable, tied low
//   busy       high from accepted start through the done cycle
//   out_valid  ROM data this cycle belongs to out_stage/out_top/out_bot
//   out_stage  stage of the butterfly on the output
//   out_top    top data index
//   out_bot    bottom data index (out_top + 2^stage)
//   out_last   final butterfly of the final stage
//   done       one-cycle completion pulse (out_valid & out_last)
module fft_twiddle_addr_gen #(
    parameter int unsigned LOG2N     = 3,
    parameter int unsigned ADDR_BASE = 1,
    parameter int unsigned AW        = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             adv,
    output logic [AW-1:0]    addr,
    output logic             wr_ena,
    output logic             busy,
    output logic             out_valid,
    output logic [LOG2N-1:0] out_stage,
    output logic [LOG2N-1:0] out_top,
    output logic [LOG2N-1:0] out_bot,
    output logic             out_last,
    output logic             done
);

    localparam int unsigned N  = 1 << LOG2N;
    // Index width; LOG2N bits also holds the butterfly counter and stage+1.
    localparam int unsigned IW = LOG2N;
    localparam logic [IW-1:0] J_LAST = IW'(N / 2 - 1);
    localparam logic [IW-1:0] S_LAST = IW'(LOG2N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   s, s_nxt;
    logic [IW-1:0]   j, j_nxt;
    logic [AW-1:0]   addr_nxt;
    logic            issue_c;
    logic            last_c;
    logic [IW-1:0]   top_c;
    logic [IW-1:0]   bot_c;

    // Position of butterfly j inside its group at stage st.
    function automatic logic [IW-1:0] grp_pos(input logic [IW-1:0] st, input logic [IW-1:0] jj);
        return jj & ((IW'(1) << st) - IW'(1));
    endfunction

    // Twiddle ROM address: k = p << (LOG2N-1-st).
    function automatic logic [AW-1:0] tw_addr(input logic [IW-1:0] st, input logic [IW-1:0] jj);
        logic [IW-1:0] k;
        k = grp_pos(st, jj) << (S_LAST - st);
        return AW'(ADDR_BASE) + AW'(k);
    endfunction

    assign wr_ena  = 1'b0;
    assign issue_c = (state == ISSUE) && adv;
    assign last_c  = (s == S_LAST) && (j == J_LAST);
    assign top_c   = ((j >> s) << (s + IW'(1))) + grp_pos(s, j);
    assign bot_c   = top_c + (IW'(1) << s);

    // Next-state and counter advance
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        j_nxt     = j;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    s_nxt     = '0;
                    j_nxt     = '0;
                end
            end
            ISSUE: begin
                if (adv) begin
                    if (j == J_LAST) begin
                        j_nxt = '0;
                        // Wrap the stage after the final issue so addr parks at ADDR_BASE.
                        s_nxt = last_c ? '0 : s + IW'(1);
                    end else begin
                        j_nxt = j + IW'(1);
                    end
                    if (last_c) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Address always follows the counters, so it holds whenever they hold.
        addr_nxt = tw_addr(s_nxt, j_nxt);
    end

    // State, counters and the one-cycle output pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= '0;
            j         <= '0;
            addr      <= AW'(ADDR_BASE);
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_stage <= '0;
            out_top   <= '0;
            out_bot   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            s         <= s_nxt;
            j         <= j_nxt;
            addr      <= addr_nxt;
            busy      <= (state_nxt != IDLE);
            out_valid <= issue_c;
            done      <= issue_c && last_c;
            if (issue_c) begin
                out_stage <= s;
                out_top   <= top_c;
                out_bot   <= bot_c;
                out_last  <= last_c;
            end
        end
    end

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Directed bench for fft_twiddle_addr_gen (N=8 instance plus an N=2 instance).
module tb_fft_twiddle_addr_gen;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        adv = 1'b1;
    logic [11:0] addr;
    logic        wr_ena, busy, out_valid, out_last, done;
    logic [2:0]  out_stage, out_top, out_bot;

    logic        start1 = 1'b0;
    logic [11:0] addr1;
    logic        wr_ena1, busy1, out_valid1, out_last1, done1;
    logic [0:0]  out_stage1, out_top1, out_bot1;

    int errors = 0;
    int checks = 0;

    int exp_addr [12] = '{1, 1, 1, 1, 1, 3, 1, 3, 1, 2, 3, 4};
    int exp_k    [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int exp_top  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_bot  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};

    real cos_tab [16];
    real sin_tab [16];
    real rom_re, rom_im;

    always #5 clk = ~clk;

    fft_twiddle_addr_gen #(.LOG2N(3), .ADDR_BASE(1), .AW(12)) dut (
        .clk(clk), .rst(rst), .start(start), .adv(adv), .addr(addr), .wr_ena(wr_ena),
        .busy(busy), .out_valid(out_valid), .out_stage(out_stage), .out_top(out_top),
        .out_bot(out_bot), .out_last(out_last), .done(done)
    );

    fft_twiddle_addr_gen #(.LOG2N(1), .ADDR_BASE(1), .AW(12)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .adv(1'b1), .addr(addr1), .wr_ena(wr_ena1),
        .busy(busy1), .out_valid(out_valid1), .out_stage(out_stage1), .out_top(out_top1),
        .out_bot(out_bot1), .out_last(out_last1), .done(done1)
    );

    // Twiddle ROM model with one-cycle read latency; entry k at address 1+k.
    always @(posedge clk) begin
        if (addr < 12'd16) begin
            rom_re <= cos_tab[addr[3:0]];
            rom_im <= sin_tab[addr[3:0]];
        end else begin
            rom_re <= 99.0;
            rom_im <= 99.0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b vld=%b done=%b last=%b exp 0000",
                     busy, out_valid, done, out_last);
        end
        checks++;
        if (addr !== 12'd1 || wr_ena !== 1'b0) begin
            errors++;
            $display("FAIL reset_addr got addr=%0d wr_ena=%b exp addr=1 wr_ena=0", addr, wr_ena);
        end
        checks++;
        if (out_stage !== 3'd0 || out_top !== 3'd0 || out_bot !== 3'd0) begin
            errors++;
            $display("FAIL reset_idx got st=%0d top=%0d bot=%0d exp 0 0 0", out_stage, out_top, out_bot);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_rst got busy=%b exp 0", busy);
        end
    endtask

    // Start a schedule, optionally stalling and pulsing extra starts, and check
    // every cycle up to and including the cycle after done. Leaves the bench in
    // that cycle (no trailing tick) so a following start lands at done+1.
    task automatic run_check(input string name, input int slo, input int shi,
                             input int p1, input int p2, input int exp_done);
        int idx;
        int vidx;
        real er, ei;
        idx = 0;
        vidx = -1;
        start = 1'b1;
        adv = 1'b1;
        tick();
        for (int c = 1; c <= exp_done + 1; c++) begin
            start = (c == p1) || (c == p2);
            adv = !(c >= slo && c <= shi);
            checks++;
            if (wr_ena !== 1'b0) begin
                errors++;
                $display("FAIL %s wr_ena c=%0d got %b exp 0", name, c, wr_ena);
            end
            checks++;
            if (busy !== (c <= exp_done)) begin
                errors++;
                $display("FAIL %s busy c=%0d got %b exp %b", name, c, busy, c <= exp_done);
            end
            checks++;
            if (done !== (c == exp_done)) begin
                errors++;
                $display("FAIL %s done c=%0d got %b exp %b", name, c, done, c == exp_done);
            end
            checks++;
            if (out_valid !== (vidx >= 0)) begin
                errors++;
                $display("FAIL %s out_valid c=%0d got %b exp %b", name, c, out_valid, vidx >= 0);
            end
            if (vidx >= 0) begin
                checks++;
                if (out_top !== 3'(exp_top[vidx]) || out_bot !== 3'(exp_bot[vidx]) ||
                    out_stage !== 3'(vidx / 4) || out_last !== (vidx == 11)) begin
                    errors++;
                    $display("FAIL %s idx c=%0d got st=%0d top=%0d bot=%0d last=%b exp st=%0d top=%0d bot=%0d last=%b",
                             name, c, out_stage, out_top, out_bot, out_last,
                             vidx / 4, exp_top[vidx], exp_bot[vidx], vidx == 11);
                end
                er = $cos(2.0 * PI * exp_k[vidx] / 8.0);
                ei = $sin(2.0 * PI * exp_k[vidx] / 8.0);
                checks++;
                if ((rom_re - er) > 1e-9 || (er - rom_re) > 1e-9 ||
                    (rom_im - ei) > 1e-9 || (ei - rom_im) > 1e-9) begin
                    errors++;
                    $display("FAIL %s rom c=%0d got re=%f im=%f exp re=%f im=%f",
                             name, c, rom_re, rom_im, er, ei);
                end
            end
            if (idx < 12) begin
                checks++;
                if (addr !== 12'(exp_addr[idx])) begin
                    errors++;
                    $display("FAIL %s addr c=%0d got %0d exp %0d", name, c, addr, exp_addr[idx]);
                end
            end
            if (adv && idx < 12) begin
                vidx = idx;
                idx++;
            end else begin
                vidx = -1;
            end
            if (c <= exp_done) tick();
        end
        start = 1'b0;
        adv = 1'b1;
    endtask

    task automatic test_full();
        run_check("full", 100, 0, -1, -1, 13);
        tick();
    endtask

    task automatic test_stall();
        run_check("stall", 4, 6, -1, -1, 16);
        tick();
    endtask

    task automatic test_final_stall();
        // Hold adv low on the final issue slot (cycle 12): done slips by two.
        run_check("final_stall", 12, 13, -1, -1, 15);
        tick();
    endtask

    task automatic test_rst_mid();
        start = 1'b1;
        adv = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            rst = (c == 7);
            tick();
        end
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || addr !== 12'd1) begin
            errors++;
            $display("FAIL rst_mid got busy=%b vld=%b done=%b addr=%0d exp 0 0 0 1",
                     busy, out_valid, done, addr);
        end
        checks++;
        if (out_top !== 3'd0 || out_bot !== 3'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idx got top=%0d bot=%0d last=%b exp 0 0 0", out_top, out_bot, out_last);
        end
        run_check("after_rst", 100, 0, -1, -1, 13);
        tick();
    endtask

    task automatic test_back_to_back();
        // Starts at cycle 5 and in the done cycle are ignored; start at done+1 runs.
        run_check("ignore_start", 100, 0, 5, 13, 13);
        run_check("back_to_back", 100, 0, -1, -1, 13);
        tick();
    endtask

    task automatic test_log2n1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || addr1 !== 12'd1 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL n2_issue got busy=%b addr=%0d vld=%b exp 1 1 0", busy1, addr1, out_valid1);
        end
        tick();
        checks++;
        if (out_valid1 !== 1'b1 || out_top1 !== 1'b0 || out_bot1 !== 1'b1 ||
            out_last1 !== 1'b1 || done1 !== 1'b1 || out_stage1 !== 1'b0) begin
            errors++;
            $display("FAIL n2_out got vld=%b top=%0d bot=%0d last=%b done=%b st=%0d exp 1 0 1 1 1 0",
                     out_valid1, out_top1, out_bot1, out_last1, done1, out_stage1);
        end
        tick();
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || out_valid1 !== 1'b0 || wr_ena1 !== 1'b0) begin
            errors++;
            $display("FAIL n2_end got busy=%b done=%b vld=%b wr=%b exp 0 0 0 0",
                     busy1, done1, out_valid1, wr_ena1);
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin
            cos_tab[a] = 99.0;
            sin_tab[a] = 99.0;
        end
        for (int k = 0; k < 8; k++) begin
            cos_tab[k + 1] = $cos(2.0 * PI * k / 8.0);
            sin_tab[k + 1] = $sin(2.0 * PI * k / 8.0);
        end
        test_reset();
        test_full();
        test_stall();
        test_final_stall();
        test_rst_mid();
        test_back_to_back();
        test_log2n1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
